// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: state encoding, key sizing, ASCII bounds and key byte select.
package arc4_pkg;

    typedef enum logic [2:0] {IDLE, RD_LEN, INIT, KSA, PRGA, DONE} state_t;

    localparam int unsigned KEYLEN_DEF = 3;
    localparam int unsigned KEY_MAX    = 16;
    localparam logic [7:0]  ASCII_LO   = 8'h20;
    localparam logic [7:0]  ASCII_HI   = 8'h7E;

    // Key byte k of an nbytes-long big-endian key, right-aligned in a KEY_MAX-byte vector.
    function automatic logic [7:0] key_byte(input logic [8*KEY_MAX-1:0] key,
                                            input int unsigned nbytes,
                                            input int unsigned k);
        return key[8*(nbytes-1-k) +: 8];
    endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Handshake, key and memory-port bundle of the ARC4 encryptor; slave = encryptor side.
interface arc4_encrypt_if #(
    parameter int unsigned KEYLEN = arc4_pkg::KEYLEN_DEF
);
    logic                  en;
    logic                  rdy;
    logic [8*KEYLEN-1:0]   key;
    logic [7:0]            s_addr;
    logic [7:0]            s_rddata;
    logic [7:0]            s_wrdata;
    logic                  s_wren;
    logic [7:0]            pt_addr;
    logic [7:0]            pt_rddata;
    logic [7:0]            ct_addr;
    logic [7:0]            ct_wrdata;
    logic                  ct_wren;
    logic                  err;

    modport master (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren, err
    );
    modport slave (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren, err
    );
endinterface

// File: rtl/arc4_ksa.sv
// S-box init (S[k]=k, 256 cycles) then key schedule (4 cycles per i: read S[i],
// read S[j], write S[i], write S[j]); done is a one-cycle pulse after the last swap.
module arc4_ksa import arc4_pkg::*; #(
    parameter int unsigned KEYLEN = KEYLEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                rdy,
    output logic                done,
    input  logic [8*KEYLEN-1:0] key,
    output logic [7:0]          s_addr,
    output logic [7:0]          s_wrdata,
    output logic                s_wren,
    input  logic [7:0]          s_rddata
);
    state_t state, state_nx;
    logic [1:0] ph;
    logic [7:0] i, j, si, kidx, kb, j_nx;
    logic [8*KEY_MAX-1:0] key_ext;

    assign key_ext = {{(8*(KEY_MAX-KEYLEN)){1'b0}}, key};
    assign kb      = key_byte(key_ext, KEYLEN, 32'(kidx));
    assign j_nx    = j + s_rddata + kb;
    assign rdy     = (state == IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ph    <= '0;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            kidx  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (en) i <= '0;
                INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'd255) begin
                        j    <= '0;
                        kidx <= '0;
                        ph   <= '0;
                    end
                end
                KSA: begin
                    ph <= ph + 2'd1;
                    if (ph == 2'd1) begin
                        si <= s_rddata;
                        j  <= j_nx;
                    end
                    if (ph == 2'd3) begin
                        i    <= i + 8'd1;
                        kidx <= (kidx == 8'(KEYLEN-1)) ? 8'd0 : kidx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (state)
            IDLE: if (en) state_nx = INIT;
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                if (i == 8'd255) state_nx = KSA;
            end
            KSA: begin
                case (ph)
                    2'd0: s_addr = i;
                    2'd1: s_addr = j_nx;
                    2'd2: begin
                        s_addr   = i;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                    end
                    default: begin
                        s_addr   = j;
                        s_wrdata = si;
                        s_wren   = 1'b1;
                        if (i == 8'd255) state_nx = DONE;
                    end
                endcase
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: pt[0]=len -> ct[0]=len, then init/KSA on S and PRGA, ct[k]=pt[k]^pad.
// rdy returns 1282+6*len edges after the accepting edge (1 edge when len=0); PRGA is 6 cycles/byte.
// Define ARC4_ENC_ASCII_CHECK_EN to flag plaintext bytes outside 0x20..0x7E on err.
module arc4_encrypt import arc4_pkg::*; #(
    parameter int unsigned KEYLEN = KEYLEN_DEF,
    parameter int unsigned MAXLEN = 255
) (
    input logic           clk,
    input logic           rst,
    arc4_encrypt_if.slave bus
);
    state_t state, state_nx;
    logic [2:0] ph;
    logic [7:0] len, len_in, k, i, j, si, sj, ptb, i_inc, j_add;
    logic [8*KEYLEN-1:0] key_q;
    logic ksa_en, ksa_rdy, ksa_done, ksa_wren, p_wren;
    logic [7:0] ksa_addr, ksa_wrdata, p_addr, p_wrdata;

    assign len_in = (bus.pt_rddata > 8'(MAXLEN)) ? 8'(MAXLEN) : bus.pt_rddata;
    assign i_inc  = i + 8'd1;
    assign j_add  = j + bus.s_rddata;
    assign bus.rdy = (state == IDLE);

    arc4_ksa #(.KEYLEN(KEYLEN)) u_ksa (
        .clk      (clk),
        .rst      (rst),
        .en       (ksa_en),
        .rdy      (ksa_rdy),
        .done     (ksa_done),
        .key      (key_q),
        .s_addr   (ksa_addr),
        .s_wrdata (ksa_wrdata),
        .s_wren   (ksa_wren),
        .s_rddata (bus.s_rddata)
    );

    // PRGA owns the S port only while it runs; elsewhere the sequencer drives it (idle = zeros).
    assign bus.s_addr   = (state == PRGA) ? p_addr   : ksa_addr;
    assign bus.s_wrdata = (state == PRGA) ? p_wrdata : ksa_wrdata;
    assign bus.s_wren   = (state == PRGA) ? p_wren   : ksa_wren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ph    <= '0;
            len   <= '0;
            k     <= '0;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            ptb   <= '0;
            key_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE:   if (bus.en) key_q <= bus.key;
                RD_LEN: len <= len_in;
                KSA: if (ksa_done) begin
                    i  <= '0;
                    j  <= '0;
                    k  <= 8'd1;
                    ph <= '0;
                end
                PRGA: begin
                    ph <= (ph == 3'd5) ? 3'd0 : ph + 3'd1;
                    case (ph)
                        3'd0: i <= i_inc;
                        3'd1: begin
                            si  <= bus.s_rddata;
                            j   <= j_add;
                            ptb <= bus.pt_rddata;
                        end
                        3'd2: sj <= bus.s_rddata;
                        3'd5: k  <= k + 8'd1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // pt_addr idles at 0, so pt[0] is already on pt_rddata in the RD_LEN cycle.
    always_comb begin
        state_nx      = state;
        ksa_en        = 1'b0;
        p_addr        = '0;
        p_wrdata      = '0;
        p_wren        = 1'b0;
        bus.pt_addr   = '0;
        bus.ct_addr   = '0;
        bus.ct_wrdata = '0;
        bus.ct_wren   = 1'b0;
        case (state)
            IDLE: if (bus.en) state_nx = RD_LEN;
            RD_LEN: begin
                bus.ct_wrdata = len_in;
                bus.ct_wren   = 1'b1;
                if (len_in == 8'd0) begin
                    state_nx = IDLE;
                end else begin
                    ksa_en   = ksa_rdy;
                    state_nx = KSA;
                end
            end
            KSA: if (ksa_done) state_nx = PRGA;
            PRGA: begin
                bus.pt_addr = k;
                case (ph)
                    3'd0: p_addr = i_inc;
                    3'd1: p_addr = j_add;
                    3'd2: begin
                        p_addr   = i;
                        p_wrdata = bus.s_rddata;
                        p_wren   = 1'b1;
                    end
                    3'd3: begin
                        p_addr   = j;
                        p_wrdata = si;
                        p_wren   = 1'b1;
                    end
                    3'd4: p_addr = si + sj;
                    default: begin
                        bus.ct_addr   = k;
                        bus.ct_wrdata = bus.s_rddata ^ ptb;
                        bus.ct_wren   = 1'b1;
                        if (k == len) state_nx = IDLE;
                    end
                endcase
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ARC4_ENC_ASCII_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (state == IDLE && bus.en)
            err_q <= 1'b0;
        else if (state == PRGA && ph == 3'd1 &&
                 (bus.pt_rddata < ASCII_LO || bus.pt_rddata > ASCII_HI))
            err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt against a plain-array RC4 reference model.
module tb_arc4_encrypt;
    typedef logic [7:0] mem_t [256];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arc4_encrypt_if bus();
    arc4_encrypt dut (.clk(clk), .rst(rst), .bus(bus));

    mem_t pt_mem, ct_mem, s_mem;
    int ct_wr_cnt = 0, ct0_wr_cnt = 0, s_wr_cnt = 0;
    int n_tests = 0, n_fail = 0;
    logic [7:0] vec [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    always @(posedge clk) begin
        if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_wrdata;
            s_wr_cnt <= s_wr_cnt + 1;
        end
        if (bus.ct_wren) begin
            ct_mem[bus.ct_addr] <= bus.ct_wrdata;
            ct_wr_cnt <= ct_wr_cnt + 1;
            if (bus.ct_addr == 8'd0) ct0_wr_cnt <= ct0_wr_cnt + 1;
        end
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.pt_rddata <= pt_mem[bus.pt_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic void rc4_model(input logic [23:0] key, input int len, input mem_t din,
                                      output mem_t dout, output mem_t s);
        int i, j, t, kb;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            kb = int'((key >> (8 * (2 - n % 3))) & 24'hFF);
            j = (j + s[n] + kb) % 256;
            t = s[n]; s[n] = s[j]; s[j] = 8'(t);
        end
        for (int n = 0; n < 256; n++) dout[n] = 8'h00;
        dout[0] = 8'(len);
        i = 0; j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = 8'(t);
            dout[n] = din[n] ^ s[(s[i] + s[j]) % 256];
        end
    endfunction

    task automatic load_str(input string msg);
        pt_mem[0] = 8'(msg.len());
        for (int n = 0; n < msg.len(); n++) pt_mem[n+1] = msg[n];
    endtask

    task automatic load_rand(input int len);
        pt_mem[0] = 8'(len);
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    endtask

    task automatic run(input string tag, input logic [23:0] key, input bit hold);
        mem_t exp_ct, exp_s;
        int len, cyc, c0, z0, s0, bad, exp_err;
        len = int'(pt_mem[0]);
        rc4_model(key, len, pt_mem, exp_ct, exp_s);
        c0 = ct_wr_cnt; z0 = ct0_wr_cnt; s0 = s_wr_cnt;
        @(negedge clk);
        bus.key = key;
        bus.en  = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.en = 1'b0;
        cyc = 0;
        while (cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rdy) break;
            if (hold && cyc == 100) bus.key = ~key;
        end
        bus.en = 1'b0;
        chk({tag, "_latency"}, cyc, (len == 0) ? 1 : 1282 + 6 * len);
        bad = 0;
        for (int n = 0; n <= len; n++) if (ct_mem[n] !== exp_ct[n]) bad++;
        chk({tag, "_ct_bad_bytes"}, bad, 0);
        chk({tag, "_ct_writes"}, ct_wr_cnt - c0, len + 1);
        chk({tag, "_ct0_writes"}, ct0_wr_cnt - z0, 1);
        chk({tag, "_s_writes"}, s_wr_cnt - s0, (len == 0) ? 0 : 768 + 2 * len);
        if (len > 0) begin
            bad = 0;
            for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
            chk({tag, "_s_bad_bytes"}, bad, 0);
        end
        exp_err = 0;
`ifdef ARC4_ENC_ASCII_CHECK_EN
        for (int n = 1; n <= len; n++)
            if (pt_mem[n] < 8'h20 || pt_mem[n] > 8'h7E) exp_err = 1;
`endif
        chk({tag, "_err"}, int'(bus.err), exp_err);
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, "_rdy_stays"}, int'(bus.rdy), 1);
            chk({tag, "_no_rerun"}, ct_wr_cnt - c0, len + 1);
        end
    endtask

    initial begin
        mem_t rec, s_dummy;
        int bad;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.key = '0;
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        #1;
        chk("rst_rdy", int'(bus.rdy), 1);
        chk("rst_s_wren", int'(bus.s_wren), 0);
        chk("rst_ct_wren", int'(bus.ct_wren), 0);
        chk("rst_addrs", int'({bus.s_addr, bus.pt_addr, bus.ct_addr}), 0);
        chk("rst_wrdata", int'({bus.s_wrdata, bus.ct_wrdata}), 0);
        chk("rst_err", int'(bus.err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        load_str("Plaintext");
        run("vec", 24'h4B6579, 1'b0);
        for (int n = 0; n < 10; n++) chk($sformatf("vec_ct%0d", n), int'(ct_mem[n]), int'(vec[n]));

        load_str("The quick brown fox jumps over the lazy dog, twice!!!");
        run("msg53", 24'h000018, 1'b0);
        rc4_model(24'h000018, int'(ct_mem[0]), ct_mem, rec, s_dummy);
        bad = 0;
        for (int n = 0; n <= 53; n++) if (rec[n] !== pt_mem[n]) bad++;
        chk("msg53_roundtrip_bad", bad, 0);

        pt_mem[0] = 8'h00;
        run("len0", 24'($urandom), 1'b0);
        chk("len0_ct0", int'(ct_mem[0]), 0);

        // abort a run partway through the key schedule
        load_str("Plaintext");
        @(negedge clk);
        bus.key = 24'h123456;
        bus.en  = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (700) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rdy", int'(bus.rdy), 1);
        chk("midrst_s_wren", int'(bus.s_wren), 0);
        chk("midrst_ct_wren", int'(bus.ct_wren), 0);
        @(negedge clk);
        rst = 1'b0;
        run("rerun", 24'h4B6579, 1'b0);
        for (int n = 0; n < 10; n++) chk($sformatf("rerun_ct%0d", n), int'(ct_mem[n]), int'(vec[n]));

        load_rand(20);
        run("hold", 24'($urandom), 1'b1);

        pt_mem[0] = 8'h03; pt_mem[1] = 8'h41; pt_mem[2] = 8'h07; pt_mem[3] = 8'h42;
        run("ascii", 24'($urandom), 1'b0);
        chk("ascii_ct0", int'(ct_mem[0]), 3);

        load_rand(255);
        run("len255", 24'($urandom), 1'b0);

        for (int r = 0; r < 4; r++) begin
            load_rand(int'($urandom_range(1, 40)));
            run($sformatf("rand%0d", r), 24'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end
endmodule
